// File: rtl/mode_output_arbiter_if.sv
// Shared bundle between the mode arbiter, the per-channel sub-system tops and the board pins.
interface mode_output_arbiter_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned LED_W  = 5
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       sel_req;
  logic [NUM_CH*4-1:0]     ch_fnd_com;
  logic [NUM_CH*8-1:0]     ch_fnd;
  logic [NUM_CH*LED_W-1:0] ch_led;
  logic [NUM_CH-1:0]       ch_tx;
  logic [NUM_CH-1:0]       ch_enable;
  logic [3:0]              fnd_com;
  logic [7:0]              fnd;
  logic [LED_W-1:0]        led;
  logic                    tx;
  logic [CH_W-1:0]         active_ch;
  logic                    switching;

  modport slave (
    input  sel_req, ch_fnd_com, ch_fnd, ch_led, ch_tx,
    output ch_enable, fnd_com, fnd, led, tx, active_ch, switching
  );

  modport master (
    output sel_req, ch_fnd_com, ch_fnd, ch_led, ch_tx,
    input  ch_enable, fnd_com, fnd, led, tx, active_ch, switching
  );
endinterface

// File: rtl/mode_output_arbiter.sv
// Debounced switch-driven arbiter of NUM_CH sub-systems onto shared FND/LED/UART pins with a
// drain-then-blank switchover. Define AUTO_SCAN_EN to rotate channels while no switch is set.
module mode_output_arbiter #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned LED_W          = 5,
  parameter int unsigned STABLE_CYCLES  = 1000000,
  parameter int unsigned TX_IDLE_CYCLES = 10417,
  parameter int unsigned DRAIN_TIMEOUT  = 2000000,
  parameter int unsigned BLANK_CYCLES   = 100000,
  parameter int unsigned SCAN_CYCLES    = 300000000
) (
  input logic                  clk,
  input logic                  rst,
  mode_output_arbiter_if.slave bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SW   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IW   = $clog2(TX_IDLE_CYCLES + 1);
  localparam int unsigned TM0  = (DRAIN_TIMEOUT > BLANK_CYCLES) ? DRAIN_TIMEOUT : BLANK_CYCLES;
  localparam int unsigned TM1  = (TM0 > SCAN_CYCLES) ? TM0 : SCAN_CYCLES;
  localparam int unsigned TW   = (TM1 > 2) ? $clog2(TM1) : 1;

  localparam logic [SW-1:0] StableMax = SW'(STABLE_CYCLES);
  localparam logic [IW-1:0] IdleDone  = IW'(TX_IDLE_CYCLES);
  localparam logic [TW-1:0] DrainLast = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [TW-1:0] BlankLast = TW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain, StBlank} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [CH_W:0]     dec, samp_q, samp_d, tgt_q, tgt_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic              tgt_valid;
  logic [CH_W-1:0]   tgt_idx;
  logic              cur_tx;
  logic [3:0]        com_q, com_d;
  logic [7:0]        fnd_q, fnd_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              tx_q, tx_d;
  logic [NUM_CH-1:0] enable;
`ifdef AUTO_SCAN_EN
  localparam logic [TW-1:0] ScanLast = TW'(SCAN_CYCLES - 1);
  logic [CH_W-1:0] scan_q, scan_d;
`endif

  assign tgt_valid = tgt_q[CH_W];
  assign tgt_idx   = tgt_q[CH_W-1:0];

  // Lowest set request bit wins; encoded as {valid, index}.
  always_comb begin
    dec = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.sel_req[i]) dec = {1'b1, CH_W'(i)};
    end
  end

  always_comb begin
    samp_d = dec;
    tgt_d  = tgt_q;
    if (dec != samp_q)          cnt_d = SW'(1);
    else if (cnt_q != StableMax) cnt_d = cnt_q + 1'b1;
    else                        cnt_d = cnt_q;
    if (cnt_d == StableMax) tgt_d = dec;
  end

  always_comb begin
    cur_tx = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (act_q == CH_W'(i)) cur_tx = bus.ch_tx[i];
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    timer_d = timer_q + 1'b1;
    idle_d  = '0;
`ifdef AUTO_SCAN_EN
    scan_d  = scan_q;
`endif
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (tgt_valid) state_d = StBlank;
`ifdef AUTO_SCAN_EN
        else begin
          state_d = StBlank;
          scan_d  = '0;
        end
`endif
      end
      StActive: begin
        if (tgt_valid) begin
          timer_d = '0;
          if (tgt_idx != act_q) state_d = StDrain;
        end else begin
`ifdef AUTO_SCAN_EN
          if (timer_q == ScanLast) begin
            state_d = StDrain;
            timer_d = '0;
            scan_d  = (act_q == CH_W'(NUM_CH - 1)) ? '0 : act_q + 1'b1;
          end
`else
          state_d = StDrain;
          timer_d = '0;
`endif
        end
      end
      StDrain: begin
        idle_d = cur_tx ? idle_q + 1'b1 : '0;
        // A target bouncing back to the live channel cancels the switch without blanking.
        if (tgt_valid && tgt_idx == act_q) begin
          state_d = StActive;
          timer_d = '0;
        end else if (idle_d == IdleDone || timer_q == DrainLast) begin
          state_d = StBlank;
          timer_d = '0;
        end
      end
      StBlank: begin
        if (timer_q == BlankLast) begin
          timer_d = '0;
          if (tgt_valid) begin
            state_d = StActive;
            act_d   = tgt_idx;
          end else begin
`ifdef AUTO_SCAN_EN
            state_d = StActive;
            act_d   = scan_q;
`else
            state_d = StIdle;
`endif
          end
        end
      end
    endcase
  end

  // Pin registers follow the next state so blanking lines up exactly with BLANK/IDLE.
  always_comb begin
    com_d = 4'hF;
    fnd_d = 8'hFF;
    led_d = '0;
    tx_d  = 1'b1;
    if (state_d == StActive || state_d == StDrain) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (act_d == CH_W'(i)) begin
          com_d = bus.ch_fnd_com[4*i +: 4];
          fnd_d = bus.ch_fnd[8*i +: 8];
          led_d = bus.ch_led[LED_W*i +: LED_W];
          tx_d  = bus.ch_tx[i];
        end
      end
    end
  end

  always_comb begin
    enable = '0;
    if (state_q == StActive || state_q == StDrain) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (act_q == CH_W'(i)) enable[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      act_q   <= '0;
      timer_q <= '0;
      idle_q  <= '0;
      samp_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      com_q   <= 4'hF;
      fnd_q   <= 8'hFF;
      led_q   <= '0;
      tx_q    <= 1'b1;
`ifdef AUTO_SCAN_EN
      scan_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      timer_q <= timer_d;
      idle_q  <= idle_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      com_q   <= com_d;
      fnd_q   <= fnd_d;
      led_q   <= led_d;
      tx_q    <= tx_d;
`ifdef AUTO_SCAN_EN
      scan_q  <= scan_d;
`endif
    end
  end

  assign bus.ch_enable = enable;
  assign bus.fnd_com   = com_q;
  assign bus.fnd       = fnd_q;
  assign bus.led       = led_q;
  assign bus.tx        = tx_q;
  assign bus.active_ch = act_q;
  assign bus.switching = (state_q == StDrain) || (state_q == StBlank);
endmodule

// File: tb/tb_mode_output_arbiter.sv
// Directed scenarios plus random segments for mode_output_arbiter, checked against a
// countdown/stamp-based behavioural model of the switchover rules.
module tb_mode_output_arbiter;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned LED_W  = 5;
  localparam int STABLE = 4;
  localparam int TXI    = 8;
  localparam int DTO    = 50;
  localparam int BLK    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mode_output_arbiter_if #(.NUM_CH(NUM_CH), .LED_W(LED_W)) bus ();

  mode_output_arbiter #(
    .NUM_CH(NUM_CH), .LED_W(LED_W), .STABLE_CYCLES(STABLE), .TX_IDLE_CYCLES(TXI),
    .DRAIN_TIMEOUT(DTO), .BLANK_CYCLES(BLK), .SCAN_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: debounce history, then "connected/draining/blank countdown" view of the arbiter.
  int m_last, m_same, m_tgt, m_ch, blank_left, drain_cycles, high_run;
  bit connected, draining;
  logic [2:0] e_en;
  logic [3:0] e_com;
  logic [7:0] e_fnd;
  logic [4:0] e_led;
  logic       e_tx;

  logic [2:0] tx_hi, tx_lo;
  int nblank, ndrain, nsw, nlow;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    bus.ch_fnd_com = 12'($urandom);
    bus.ch_fnd     = 24'($urandom);
    bus.ch_led     = 15'($urandom);
    bus.ch_tx      = (3'($urandom) & ~tx_lo) | tx_hi;
  endtask

  task automatic model_step();
    int dec;
    int old_tgt;
    if (!rst) begin
      m_last = -1; m_same = 0; m_tgt = -1; m_ch = 0;
      blank_left = 0; drain_cycles = 0; high_run = 0;
      connected = 0; draining = 0;
    end else begin
      old_tgt = m_tgt;
      dec = -1;
      for (int i = NUM_CH - 1; i >= 0; i--) if (bus.sel_req[i]) dec = i;
      if (dec != m_last) begin
        m_last = dec;
        m_same = 1;
      end else begin
        m_same++;
      end
      if (m_same >= STABLE) m_tgt = dec;

      if (blank_left > 0) begin
        blank_left--;
        if (blank_left == 0 && old_tgt >= 0) begin
          connected = 1;
          draining  = 0;
          m_ch      = old_tgt;
        end
      end else if (!connected) begin
        if (old_tgt >= 0) blank_left = BLK;
      end else if (!draining) begin
        if (old_tgt != m_ch) begin
          draining = 1; drain_cycles = 0; high_run = 0;
        end
      end else begin
        drain_cycles++;
        high_run = bus.ch_tx[m_ch] ? high_run + 1 : 0;
        if (old_tgt == m_ch) begin
          draining = 0;
        end else if (high_run >= TXI || drain_cycles >= DTO) begin
          connected = 0; draining = 0; blank_left = BLK;
        end
      end
    end
    if (connected) begin
      e_en  = 3'(1 << m_ch);
      e_com = bus.ch_fnd_com[m_ch*4 +: 4];
      e_fnd = bus.ch_fnd[m_ch*8 +: 8];
      e_led = bus.ch_led[m_ch*5 +: 5];
      e_tx  = bus.ch_tx[m_ch];
    end else begin
      e_en = 3'b000; e_com = 4'hF; e_fnd = 8'hFF; e_led = 5'h00; e_tx = 1'b1;
    end
  endtask

  task automatic check_all();
    check("ch_enable", 32'(bus.ch_enable), 32'(e_en));
    check("fnd_com",   32'(bus.fnd_com),   32'(e_com));
    check("fnd",       32'(bus.fnd),       32'(e_fnd));
    check("led",       32'(bus.led),       32'(e_led));
    check("tx",        32'(bus.tx),        32'(e_tx));
    check("active_ch", 32'(bus.active_ch), 32'(m_ch));
    check("switching", 32'(bus.switching), 32'(draining || blank_left > 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    rand_data();
  endtask

  initial begin
    tx_hi = 3'b000;
    tx_lo = 3'b000;
    bus.sel_req = 3'b010;
    rand_data();

    // Reset with busy inputs
    repeat (3) tick();
    check("rst_fnd", 32'(bus.fnd), 32'h0FF);
    check("rst_tx", 32'(bus.tx), 32'h1);
    rst = 1'b1;

    // IDLE -> BLANK -> ch1
    nblank = 0;
    repeat (12) begin
      tick();
      if (bus.switching) nblank++;
    end
    check("s2_blank_cycles", 32'(nblank), 32'd4);
    check("s2_active", 32'(bus.active_ch), 32'd1);
    check("s2_enable", 32'(bus.ch_enable), 32'b010);

    // ch1 -> ch2 with tx1 toggling then idle
    bus.sel_req = 3'b100;
    nblank = 0;
    nlow = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 20) begin
        tx_hi = (i % 3 != 0) ? 3'b010 : 3'b000;
        tx_lo = (i % 3 == 0) ? 3'b010 : 3'b000;
      end else begin
        tx_hi = 3'b010;
        tx_lo = 3'b000;
      end
      tick();
      if (bus.switching && bus.ch_enable == 3'b000) begin
        nblank++;
        if (!bus.tx) nlow++;
      end
    end
    check("s3_blank_cycles", 32'(nblank), 32'd4);
    check("s3_blank_tx_low", 32'(nlow), 32'd0);
    check("s3_active", 32'(bus.active_ch), 32'd2);

    // Short glitch is filtered
    tx_hi = 3'b111;
    tx_lo = 3'b000;
    nsw = 0;
    bus.sel_req = 3'b010;
    repeat (2) begin tick(); if (bus.switching) nsw++; end
    bus.sel_req = 3'b100;
    repeat (10) begin tick(); if (bus.switching) nsw++; end
    check("s4_no_switch", 32'(nsw), 32'd0);
    check("s4_active", 32'(bus.active_ch), 32'd2);

    bus.sel_req = 3'b001;
    repeat (25) tick();
    check("to_ch0", 32'(bus.active_ch), 32'd0);

    // Drain timeout with tx0 stuck low
    tx_hi = 3'b000;
    tx_lo = 3'b001;
    bus.sel_req = 3'b100;
    nblank = 0;
    ndrain = 0;
    repeat (70) begin
      tick();
      if (bus.switching && bus.ch_enable != 3'b000) ndrain++;
      if (bus.switching && bus.ch_enable == 3'b000) nblank++;
    end
    check("s5_drain_cycles", 32'(ndrain), 32'd50);
    check("s5_blank_cycles", 32'(nblank), 32'd4);
    check("s5_active", 32'(bus.active_ch), 32'd2);

    // Target returns during DRAIN
    tx_lo = 3'b100;
    nblank = 0;
    ndrain = 0;
    bus.sel_req = 3'b001;
    repeat (6) begin
      tick();
      if (bus.switching && bus.ch_enable != 3'b000) ndrain++;
      if (bus.switching && bus.ch_enable == 3'b000) nblank++;
    end
    bus.sel_req = 3'b100;
    repeat (12) begin
      tick();
      if (bus.switching && bus.ch_enable != 3'b000) ndrain++;
      if (bus.switching && bus.ch_enable == 3'b000) nblank++;
    end
    check("s6_drain_seen", 32'(ndrain > 0), 32'd1);
    check("s6_no_blank", 32'(nblank), 32'd0);
    check("s6_still_ch2", 32'(bus.active_ch), 32'd2);

    // Multiple requests: lowest index wins
    tx_hi = 3'b111;
    tx_lo = 3'b000;
    bus.sel_req = 3'b011;
    repeat (25) tick();
    check("s6_lowest_wins", 32'(bus.active_ch), 32'd0);

    // Random segments
    for (int s = 0; s < 40; s++) begin
      bus.sel_req = 3'($urandom_range(0, 7));
      tx_hi = 3'($urandom);
      tx_lo = 3'($urandom) & ~tx_hi;
      repeat ($urandom_range(1, 12)) tick();
    end

    // Reset mid-DRAIN aborts to the reset state
    tx_hi = 3'b111;
    tx_lo = 3'b000;
    bus.sel_req = 3'b001;
    repeat (30) tick();
    tx_hi = 3'b000;
    tx_lo = 3'b001;
    bus.sel_req = 3'b100;
    repeat (7) tick();
    check("pre_rst_drain", 32'(bus.switching), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_abort_switching", 32'(bus.switching), 32'd0);
    check("rst_abort_enable", 32'(bus.ch_enable), 32'd0);
    repeat (15) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
